control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cs_pkg.sv | 98 +++++++++
 rtl/control_sequencer_if.sv | 31 +++
 rtl/cs_wait_ctr.sv | 31 +++
 rtl/control_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// cs_pkg -- shared definitions for the control sequencer.
// Opcode map, ALU op codes, FSM state and opcode-class enums, strobe bundle.
// MULDIV_EN: when defined, mul/div get their own execute sequence;
// otherwise they decode like nop.
package cs_pkg;

   localparam int OP_W   = 5;
   localparam int WAIT_W = 3;

   // Opcodes (ir[31:27]); ALU operations reuse the opcode value.
   localparam logic [OP_W-1:0] OP_LD   = 5'h00;
   localparam logic [OP_W-1:0] OP_LDI  = 5'h01;
   localparam logic [OP_W-1:0] OP_ST   = 5'h02;
   localparam logic [OP_W-1:0] OP_SUB  = 5'h03;
   localparam logic [OP_W-1:0] OP_AND  = 5'h04;
   localparam logic [OP_W-1:0] OP_OR   = 5'h05;
   localparam logic [OP_W-1:0] OP_SHL  = 5'h06;
   localparam logic [OP_W-1:0] OP_SHR  = 5'h07;
   localparam logic [OP_W-1:0] OP_SHRA = 5'h08;
   localparam logic [OP_W-1:0] OP_ROL  = 5'h09;
   localparam logic [OP_W-1:0] OP_ROR  = 5'h0A;
   localparam logic [OP_W-1:0] OP_ADDI = 5'h0B;
   localparam logic [OP_W-1:0] OP_ANDI = 5'h0C;
   localparam logic [OP_W-1:0] OP_ORI  = 5'h0D;
   localparam logic [OP_W-1:0] OP_MUL  = 5'h0E;
   localparam logic [OP_W-1:0] OP_DIV  = 5'h0F;
   localparam logic [OP_W-1:0] OP_BR   = 5'h10;
   localparam logic [OP_W-1:0] OP_JR   = 5'h11;
   localparam logic [OP_W-1:0] OP_JAL  = 5'h12;
   localparam logic [OP_W-1:0] OP_IN   = 5'h13;
   localparam logic [OP_W-1:0] OP_OUT  = 5'h14;
   localparam logic [OP_W-1:0] OP_MFHI = 5'h15;
   localparam logic [OP_W-1:0] OP_MFLO = 5'h16;
   localparam logic [OP_W-1:0] OP_NOP  = 5'h17;
   localparam logic [OP_W-1:0] OP_ADD  = 5'h18;
   localparam logic [OP_W-1:0] OP_HALT = 5'h19;

   localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

   // jal writes its return address here (datapath forces Grb to this index).
   localparam logic [3:0] JAL_LINK_REG = 4'd15;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP, CL_RALU, CL_IALU, CL_LD, CL_LDI, CL_ST, CL_BR, CL_JR, CL_JAL,
      CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_MULDIV, CL_HALT
   } op_class_t;

   // Field order matches the flattened assignment in the top module.
   typedef struct packed {
      logic run;
      logic PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, Rout, BAout;
      logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONN_in, Rin, incPC;
      logic Gra, Grb, Grc, read, write;
      logic [OP_W-1:0] alu_op;
   } ctl_t;

   function automatic op_class_t classify(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR:
            classify = CL_RALU;
         OP_ADDI, OP_ANDI, OP_ORI: classify = CL_IALU;
         OP_LD:   classify = CL_LD;
         OP_LDI:  classify = CL_LDI;
         OP_ST:   classify = CL_ST;
         OP_BR:   classify = CL_BR;
         OP_JR:   classify = CL_JR;
         OP_JAL:  classify = CL_JAL;
         OP_IN:   classify = CL_IN;
         OP_OUT:  classify = CL_OUT;
         OP_MFHI: classify = CL_MFHI;
         OP_MFLO: classify = CL_MFLO;
         OP_NOP:  classify = CL_NOP;
         OP_HALT: classify = CL_HALT;
`ifdef MULDIV_EN
         OP_MUL, OP_DIV: classify = CL_MULDIV;
`else
         OP_MUL, OP_DIV: classify = CL_NOP;
`endif
         default: classify = CL_NOP;
      endcase
   endfunction

   // Final execute state of each class: where stop is sampled.
   function automatic state_t last_exec_state(input op_class_t cl);
      case (cl)
         CL_RALU, CL_IALU, CL_LDI: last_exec_state = ST_T5;
         CL_LD, CL_ST:             last_exec_state = ST_T7;
         CL_BR, CL_MULDIV:         last_exec_state = ST_T6;
         CL_JAL:                   last_exec_state = ST_T4;
         default:                  last_exec_state = ST_T3;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if -- IR/condition/run-control inputs and all datapath
// strobes of the control sequencer. master = sequencer, slave = datapath.
interface control_sequencer_if;
   import cs_pkg::*;

   logic [31:0]     ir;
   logic            con_ff;
   logic            stop;
   logic            start;
   logic            run;
   logic            PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, Rout, BAout;
   logic            PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONN_in, Rin, incPC;
   logic            Gra, Grb, Grc, read, write;
   logic [OP_W-1:0] alu_op;

   modport master (
      input  ir, con_ff, stop, start,
      output run,
      output PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, Rout, BAout,
      output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONN_in, Rin, incPC,
      output Gra, Grb, Grc, read, write, alu_op
   );

   modport slave (
      output ir, con_ff, stop, start,
      input  run,
      input  PCout, MDRout, ZHighOut, ZLowOut, HIout, LOout, InPortOut, Cout, Rout, BAout,
      input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortIn, CONN_in, Rin, incPC,
      input  Gra, Grb, Grc, read, write, alu_op
   );
endinterface

// File: rtl/cs_wait_ctr.sv
// cs_wait_ctr -- 3-bit load/decrement counter timing memory-read holds.
// done_o is high whenever the count has reached zero.
module cs_wait_ctr
   import cs_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              load_i,
   input  logic [WAIT_W-1:0] load_val_i,
   input  logic              dec_i,
   output logic              done_o
);
   logic [WAIT_W-1:0] count_q, count_d;

   // Load wins over decrement; the count never wraps below zero.
   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (dec_i && count_q != '0)
         count_d = count_q - 1'b1;
   end

   // Count register, cleared asynchronously with the sequencer.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) count_q <= '0;
      else      count_q <= count_d;
   end

   assign done_o = (count_q == '0);
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- Moore control unit: fetch (T0-T2), execute (T3-T7),
// RESET and HALT. Strobes are decoded from the state register and the
// (registered) IR opcode / CONN flag only; stop/start only steer transitions.
// MULDIV_EN: enables the mul/div execute sequence (else they act as nop).
module control_sequencer
   import cs_pkg::*;
#(
   parameter int MEM_WAIT        = 1,
   parameter int RESET_PC_CYCLES = 1
) (
   input  logic                clk,
   input  logic                clr,
   control_sequencer_if.master bus
);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT - 1);
   localparam logic [1:0]        RST_LAST  = 2'(RESET_PC_CYCLES - 1);

   state_t     state_q;
   logic [1:0] rst_cnt_q;
   op_class_t  op_class;
   logic       ctr_load, ctr_dec, wait_done;
   ctl_t       ctl;
   logic       unused_ir;

   assign op_class  = classify(bus.ir[31:27]);
   assign unused_ir = ^bus.ir[26:0];

   // Memory-read holds: armed entering T1 (from T0) and ld's T6 (from T5).
   assign ctr_load = (state_q == ST_T0) || (state_q == ST_T5 && op_class == CL_LD);
   assign ctr_dec  = ((state_q == ST_T1) || (state_q == ST_T6 && op_class == CL_LD)) && !wait_done;

   cs_wait_ctr u_wait (
      .clk        (clk),
      .clr        (clr),
      .load_i     (ctr_load),
      .load_val_i (WAIT_LOAD),
      .dec_i      (ctr_dec),
      .done_o     (wait_done)
   );

   // State sequencing; stop is looked at only in the final execute state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= ST_RESET;
         rst_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_RESET: begin
               if (rst_cnt_q == RST_LAST) begin
                  state_q   <= ST_T0;
                  rst_cnt_q <= '0;
               end else begin
                  rst_cnt_q <= rst_cnt_q + 2'd1;
               end
            end
            ST_T0:   state_q <= ST_T1;
            ST_T1:   if (wait_done) state_q <= ST_T2;
            ST_T2:   state_q <= ST_T3;
            ST_HALT: if (bus.start) state_q <= ST_T0;
            default: begin
               if (op_class == CL_HALT)
                  state_q <= ST_HALT;
               else if (state_q == last_exec_state(op_class))
                  state_q <= bus.stop ? ST_HALT : ST_T0;
               else if (!(state_q == ST_T6 && op_class == CL_LD && !wait_done))
                  state_q <= state_t'(state_q + 4'd1);
            end
         endcase
      end
   end

   // Strobe decode per state and opcode class; alu_op defaults to ADD.
   always_comb begin
      ctl        = '0;
      ctl.run    = 1'b1;
      ctl.alu_op = ALU_ADD;
      case (state_q)
         ST_RESET: begin ctl.run = 1'b0; ctl.alu_op = '0; end
         ST_HALT:  ctl.run = 1'b0;
         ST_T0:    begin ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.incPC = 1'b1; end
         ST_T1:    begin ctl.read = 1'b1; ctl.MDRin = 1'b1; end
         ST_T2:    begin ctl.MDRout = 1'b1; ctl.IRin = 1'b1; end
         ST_T3: case (op_class)
            CL_RALU, CL_IALU:    begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
            CL_LD, CL_LDI, CL_ST: begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Yin = 1'b1; end
            CL_BR:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONN_in = 1'b1; end
            CL_JR:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
            CL_JAL:    begin ctl.PCout = 1'b1; ctl.Grb = 1'b1; ctl.Rin = 1'b1; end
            CL_IN:     begin ctl.InPortOut = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            CL_OUT:    begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.OutPortIn = 1'b1; end
            CL_MFHI:   begin ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            CL_MFLO:   begin ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            CL_MULDIV: begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
            default: ;
         endcase
         ST_T4: case (op_class)
            CL_RALU:   begin ctl.Grc = 1'b1; ctl.Rout = 1'b1; ctl.Zin = 1'b1; ctl.alu_op = bus.ir[31:27]; end
            CL_IALU:   begin ctl.Cout = 1'b1; ctl.Zin = 1'b1; ctl.alu_op = bus.ir[31:27]; end
            CL_LD, CL_LDI, CL_ST: begin ctl.Cout = 1'b1; ctl.Zin = 1'b1; end
            CL_BR:     begin ctl.PCout = 1'b1; ctl.Yin = 1'b1; end
            CL_JAL:    begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
            CL_MULDIV: begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zin = 1'b1; ctl.alu_op = bus.ir[31:27]; end
            default: ;
         endcase
         ST_T5: case (op_class)
            CL_RALU, CL_IALU, CL_LDI: begin ctl.ZLowOut = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            CL_LD, CL_ST: begin ctl.ZLowOut = 1'b1; ctl.MARin = 1'b1; end
            CL_BR:        begin ctl.Cout = 1'b1; ctl.Zin = 1'b1; end
            CL_MULDIV:    begin ctl.ZLowOut = 1'b1; ctl.LOin = 1'b1; end
            default: ;
         endcase
         ST_T6: case (op_class)
            CL_LD:     begin ctl.read = 1'b1; ctl.MDRin = 1'b1; end
            CL_ST:     begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRin = 1'b1; end
            CL_BR:     begin ctl.ZLowOut = 1'b1; ctl.PCin = bus.con_ff; end
            CL_MULDIV: begin ctl.ZHighOut = 1'b1; ctl.HIin = 1'b1; end
            default: ;
         endcase
         ST_T7: case (op_class)
            CL_LD:   begin ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
            CL_ST:   ctl.write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

   assign {bus.run,
           bus.PCout, bus.MDRout, bus.ZHighOut, bus.ZLowOut, bus.HIout, bus.LOout,
           bus.InPortOut, bus.Cout, bus.Rout, bus.BAout,
           bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin,
           bus.OutPortIn, bus.CONN_in, bus.Rin, bus.incPC,
           bus.Gra, bus.Grb, bus.Grc, bus.read, bus.write, bus.alu_op} = ctl;
endmodule
